fetch_cache_unit: RTL and testbench
===================================

# fetch_cache_unit

Parametrised instruction-fetch stage for the MIPS pipeline. It holds the PC, looks up a direct-mapped instruction cache with configurable depth and line width, and refills missed lines from memory through a request/ready handshake. It accepts branch redirects and a back-pressure stall, and presents one instruction per cycle with a valid flag to the IF/ID register.

## Interface
- ADDR_W, 32, PC and memory address width
- LINE_WORDS, 4, 32-bit instructions per cache line (power of 2, ≥2)
- SETS, 16, cache lines (power of 2, ≥2)
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  downstream cannot accept; hold PC and outputs
- redirect_valid  in  1  branch/jump taken this cycle (PCSrc)
- redirect_pc  in  ADDR_W  redirect target (pc_branch)
- mem_req  out  1  line-refill request
- mem_addr  out  ADDR_W  line-aligned refill address
- mem_ready  in  1  mem_rdata valid; completes refill
- mem_rdata  in  32*LINE_WORDS  refill line; word 0 in bits [31:0]
- instr_valid  out  1  instruction/pc valid this cycle
- instruction  out  32  fetched instruction
- pc  out  ADDR_W  address of instruction
- pc_plus4  out  ADDR_W  pc+4 (add_out)
- hit  out  1  current lookup hits
- hit_count, miss_count  out  32 each  present only with FETCH_STATS_EN

## Operation
- Address split: [1:0] byte, next log2(LINE_WORDS) bits word, next log2(SETS) bits index, remainder tag.
- Per set: valid bit, tag, line data.
- States: RUN, MISS.
- RUN
  - hit = valid[idx] && tag match (combinational).
  - instr_valid = hit.
  - If redirect_valid: pc <= {redirect_pc[ADDR_W-1:2],2'b00}, regardless of stall or hit.
  - Else if hit && !stall: pc <= pc+4.
  - Else if !hit: go to MISS. Register mem_addr = pc with low log2(LINE_WORDS)+2 bits cleared, and assert mem_req.
- MISS
  - mem_req=1, instr_valid=0, hit=0; mem_addr held.
  - redirect_valid is captured into a pending-redirect register; a later redirect overwrites an earlier one.
  - On the edge with mem_ready=1: write line data, tag, valid; mem_req <= 0; go to RUN.
  - On that same edge, pc <= pending target if one exists (the refilled line is still installed), else pc unchanged.
  - Redirect arriving on the mem_ready cycle counts as pending.
- stall has no effect in MISS; the refill proceeds.
- Arithmetic: pc and pc_plus4 wrap modulo 2^ADDR_W (0xFFFFFFFC+4 = 0).
- Refill of a valid set overwrites it (no write-back; the cache is read-only).
- Reset values
  - pc=RESET_PC; state=RUN; valid bits all 0; pending cleared; mem_req=0; mem_addr=0.
  - instr_valid/hit follow the lookup, so they are 0 after reset.
  - Counters 0.
- rst during MISS aborts the request; mem_req drops the next cycle and the line is not written.

## Timing
- Hit: zero-cycle lookup from the pc register; sustained throughput of 1 instruction/cycle.
- Miss: first RUN cycle shows hit=0. The next cycle has mem_req=1. mem_ready in cycle k writes the line; the cycle after is RUN with hit=1. Penalty = 2 + wait cycles.
- Redirect in RUN: the target is visible on pc the next cycle; the lookup occurs there.
- mem_ready while mem_req=0 is ignored.

## Configuration
- FETCH_STATS_EN defined
  - hit_count increments on every accepted instruction (instr_valid && !stall && !redirect_valid).
  - miss_count increments on each RUN→MISS transition.
  - Both saturate at 0xFFFFFFFF and are cleared by rst.
- FETCH_STATS_EN undefined: counter ports and logic are absent; behaviour is otherwise identical.

## Structure
- Shared package fetch_pkg: state enum (RUN, MISS), INSTR_W=32, NOP constant, helper functions for index/tag/offset extraction from the parameters.
- Sub-module fetch_icache: tag/valid/data arrays, combinational lookup, and refill write port. The top holds the PC, FSM, pending redirect and counters.

## Test plan
- Reset, RESET_PC=0x0: first cycle hit=0, instr_valid=0. mem_req rises next cycle with mem_addr=0x0. Return a line with mem_ready after 3 cycles; the following cycle shows instruction=word0, pc=0, pc_plus4=4. Then 4 consecutive hits with pc 0,4,8,C.
- Warm line, stall held 3 cycles at pc=0x8: pc and instruction are unchanged and instr_valid stays 1. hit_count rises only after stall releases.
- Redirect to 0x43 while hitting: next cycle pc=0x40. A miss follows, with mem_addr=0x40.
- Redirect to 0x100 during MISS for 0x20: the line at 0x20 is still installed. Next pc=0x100. A later fetch of 0x20 hits with no mem_req.
- Conflict (SETS=16, LINE_WORDS=4): fetch 0x000, then 0x100 (same index). The second evicts the first, and refetching 0x000 misses. miss_count=3 with FETCH_STATS_EN.
- rst asserted during MISS: mem_req=0 the next cycle, all lines invalid, pc=RESET_PC. A late mem_ready is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared definitions for the instruction-fetch stage: FSM state
//                type, instruction width, NOP encoding, and helpers that derive
//                the byte/word/index/tag bit positions of a fetch address from
//                the cache geometry parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_W = 32;

    // All-zero word is "sll $0,$0,0", the canonical MIPS NOP.
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        MISS = 1'b1
    } fetch_state_t;

    // Width of the word-within-line field, which sits directly above the
    // two byte-offset bits.
    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Lowest bit of the set index; also the number of low address bits
    // cleared to form a line-aligned address.
    function automatic int index_lsb(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    // Lowest bit of the tag: everything above byte, word and index fields.
    function automatic int tag_lsb(input int line_words, input int sets);
        return $clog2(line_words) + 2 + $clog2(sets);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_icache.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_icache
//  Description : Direct-mapped, read-only instruction cache. Holds per-set
//                valid bit, tag and line data. Lookup is purely combinational;
//                a whole line is written in one cycle through the fill port.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                                    (invalidates every set)
//                lookup_addr       - byte address being fetched
//                lookup_hit        - set valid and tag matches
//                lookup_data       - addressed word of the indexed line
//                fill_en           - write fill_data into the set of fill_addr
//                fill_addr         - line address of the refill
//                fill_data         - refill line, word 0 in bits [31:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_icache
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             lookup_addr,
    output logic                          lookup_hit,
    output logic [INSTR_W-1:0]            lookup_data,
    input  logic                          fill_en,
    input  logic [ADDR_W-1:0]             fill_addr,
    input  logic [INSTR_W*LINE_WORDS-1:0] fill_data
);

    localparam int c_word_w  = offset_w(LINE_WORDS);
    localparam int c_idx_lsb = index_lsb(LINE_WORDS);
    localparam int c_idx_w   = index_w(SETS);
    localparam int c_tag_lsb = tag_lsb(LINE_WORDS, SETS);
    localparam int c_tag_w   = ADDR_W - c_tag_lsb;

    logic [SETS-1:0]                 r_valid;
    logic [c_tag_w-1:0]              r_tag  [SETS];
    logic [INSTR_W*LINE_WORDS-1:0]   r_data [SETS];

    logic [c_idx_w-1:0]  w_lk_idx;
    logic [c_tag_w-1:0]  w_lk_tag;
    logic [c_word_w-1:0] w_lk_word;
    logic [c_idx_w-1:0]  w_fill_idx;
    logic [c_tag_w-1:0]  w_fill_tag;
    logic [INSTR_W-1:0]  w_line_words [LINE_WORDS];
    logic                w_unused_bits;

    assign w_lk_idx   = lookup_addr[c_idx_lsb +: c_idx_w];
    assign w_lk_tag   = lookup_addr[ADDR_W-1:c_tag_lsb];
    assign w_lk_word  = lookup_addr[2 +: c_word_w];
    assign w_fill_idx = fill_addr[c_idx_lsb +: c_idx_w];
    assign w_fill_tag = fill_addr[ADDR_W-1:c_tag_lsb];

    // Byte offset and the line offset of the refill address carry no
    // information here.
    assign w_unused_bits = ^{lookup_addr[1:0], fill_addr[c_idx_lsb-1:0]};

    // Split the indexed line into words so the word field selects directly.
    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_word_split
        assign w_line_words[g] = r_data[w_lk_idx][g*INSTR_W +: INSTR_W];
    end

    assign lookup_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign lookup_data = w_line_words[w_lk_word];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (fill_en) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only observed through valid.
    always_ff @(posedge clk) begin
        if (fill_en && !rst) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= fill_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_cache_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_cache_unit
//  Description : MIPS instruction-fetch stage. Holds the PC, looks it up in a
//                direct-mapped I-cache and refills missing lines from memory
//                via a req/ready handshake. Supports branch redirects (also
//                while a refill is outstanding) and downstream stall.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                stall                  - hold PC and outputs
//                redirect_valid/_pc     - taken branch/jump and its target
//                mem_req/mem_addr       - line refill request, line-aligned
//                mem_ready/mem_rdata    - refill completion and line data
//                instr_valid            - instruction/pc valid this cycle
//                instruction, pc        - fetched word and its address
//                pc_plus4               - pc + 4
//                hit                    - current lookup hits
//                hit_count, miss_count  - saturating statistics, present only
//                                         when FETCH_STATS_EN is defined
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_cache_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                LINE_WORDS = 4,
    parameter int                SETS       = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          redirect_valid,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ready,
    input  logic [INSTR_W*LINE_WORDS-1:0] mem_rdata,
    output logic                          instr_valid,
    output logic [INSTR_W-1:0]            instruction,
    output logic [ADDR_W-1:0]             pc,
    output logic [ADDR_W-1:0]             pc_plus4,
    output logic                          hit
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
`endif
);

    localparam int                c_off_lsb = index_lsb(LINE_WORDS);
    localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(4);

    fetch_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_pend_valid, w_pend_valid_nxt;
    logic [ADDR_W-1:0] r_pend_pc, w_pend_pc_nxt;

    logic [ADDR_W-1:0]  w_redirect_tgt;
    logic [ADDR_W-1:0]  w_line_addr;
    logic               w_cache_hit;
    logic [INSTR_W-1:0] w_cache_data;
    logic               w_fill_en;
    logic               w_unused_bits;

    assign w_redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_line_addr    = {r_pc[ADDR_W-1:c_off_lsb], {c_off_lsb{1'b0}}};
    assign w_unused_bits  = ^redirect_pc[1:0];

    fetch_icache #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS)
    ) u_icache (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (r_pc),
        .lookup_hit  (w_cache_hit),
        .lookup_data (w_cache_data),
        .fill_en     (w_fill_en),
        .fill_addr   (r_mem_addr),
        .fill_data   (mem_rdata)
    );

    // The tag store may match during a refill; hit is only meaningful in RUN.
    assign hit         = (r_state == RUN) && w_cache_hit;
    assign instr_valid = hit;
    assign instruction = hit ? w_cache_data : NOP;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + c_pc_step;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_pc         <= RESET_PC;
            r_mem_addr   <= '0;
            r_mem_req    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_req_nxt    = r_mem_req;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_pc_nxt    = r_pend_pc;
        w_fill_en        = 1'b0;

        case (r_state)
            RUN: begin
                if (redirect_valid) begin
                    // A redirect wins over both stall and a pending miss.
                    w_pc_nxt = w_redirect_tgt;
                end else if (w_cache_hit) begin
                    if (!stall) begin
                        w_pc_nxt = r_pc + c_pc_step;
                    end
                end else begin
                    w_state_nxt    = MISS;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = w_line_addr;
                end
            end

            MISS: begin
                // Latest redirect wins; the refill still completes so the
                // requested line is installed regardless.
                if (redirect_valid) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_pc_nxt    = w_redirect_tgt;
                end
                if (mem_ready) begin
                    w_fill_en        = 1'b1;
                    w_state_nxt      = RUN;
                    w_mem_req_nxt    = 1'b0;
                    w_pend_valid_nxt = 1'b0;
                    if (redirect_valid) begin
                        w_pc_nxt = w_redirect_tgt;
                    end else if (r_pend_valid) begin
                        w_pc_nxt = r_pend_pc;
                    end
                end
            end

            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

`ifdef FETCH_STATS_EN
    logic        w_accept;
    logic        w_miss_start;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    assign w_accept     = hit && !stall && !redirect_valid;
    assign w_miss_start = (r_state == RUN) && !redirect_valid && !w_cache_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_accept && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss_start && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_cache_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_cache_unit
//  Description : Self-checking bench for fetch_cache_unit with default
//                geometry (16 sets x 4 words). A reference model tracks which
//                line address occupies each set, the PC, the outstanding
//                refill and any pending redirect, and predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_cache_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic [127:0] mem_rdata;
    logic         instr_valid;
    logic [31:0]  instruction;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         hit;
`ifdef FETCH_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    always #5 clk = ~clk;

    fetch_cache_unit #(
        .ADDR_W     (32),
        .LINE_WORDS (4),
        .SETS       (16),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .hit            (hit)
`ifdef FETCH_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc, m_mem_addr, m_pend_pc, m_hits, m_misses;
    bit          m_miss, m_pend;
    bit          m_valid [16];
    logic [31:0] m_line  [16];   // line address (byte address / 16) per set

    // Memory contents: a distinct word for every byte address in use.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ ~a[15:0]};
    endfunction

    function automatic logic [127:0] line_at(input logic [31:0] base);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = word_at(base + 32'(4*w));
        return l;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a / 16) % 16);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_mem_addr = 32'h0; m_pend_pc = 32'h0;
        m_hits = 0; m_misses = 0; m_miss = 0; m_pend = 0;
        for (int s = 0; s < 16; s++) begin
            m_valid[s] = 0;
            m_line[s]  = 32'h0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    endtask

    // One clock cycle: called at a falling edge, drives inputs, checks the
    // outputs against the model, advances the model, returns at the next
    // falling edge.
    task automatic cyc(input logic r, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic mr);
        bit exp_hit;
        int s;
        rst = r; stall = st; redirect_valid = rv; redirect_pc = rpc;
        mem_ready = mr; mem_rdata = line_at(m_mem_addr);
        #1;
        s = set_of(m_pc);
        exp_hit = !m_miss && m_valid[s] && (m_line[s] == m_pc / 16);
        chk("hit", 32'(hit), 32'(exp_hit));
        chk("instr_valid", 32'(instr_valid), 32'(exp_hit));
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("mem_req", 32'(mem_req), 32'(m_miss));
        if (m_miss) chk("mem_addr", mem_addr, m_mem_addr);
        if (exp_hit) chk("instruction", instruction, word_at(m_pc));
`ifdef FETCH_STATS_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
`endif
        if (r) begin
            model_reset();
        end else if (!m_miss) begin
            if (exp_hit && !st && !rv && m_hits != 32'hFFFF_FFFF) m_hits++;
            if (rv) begin
                m_pc = {rpc[31:2], 2'b00};
            end else if (exp_hit) begin
                if (!st) m_pc = m_pc + 32'd4;
            end else begin
                m_miss     = 1;
                m_mem_addr = m_pc & ~32'hF;
                if (m_misses != 32'hFFFF_FFFF) m_misses++;
            end
        end else begin
            if (rv) begin
                m_pend    = 1;
                m_pend_pc = {rpc[31:2], 2'b00};
            end
            if (mr) begin
                m_valid[set_of(m_mem_addr)] = 1;
                m_line[set_of(m_mem_addr)]  = m_mem_addr / 16;
                m_miss = 0;
                if (m_pend) m_pc = m_pend_pc;
                m_pend = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_ready = 1'b0; mem_rdata = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);                 // reset state observed

        // Cold miss at 0x0, data returned on the third MISS cycle
        cyc(0, 0, 0, 0, 0);                 // RUN, hit=0
        cyc(0, 0, 0, 0, 0);                 // MISS, mem_req, mem_addr=0
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);                 // mem_ready
        chk("cold_pc", pc, 32'h0);
        chk("cold_instr", instruction, word_at(32'h0));
        chk("cold_plus4", pc_plus4, 32'h4);
        cyc(0, 0, 0, 0, 0);                 // pc 0
        cyc(0, 0, 0, 0, 0);                 // pc 4

        // Stall for 3 cycles at 0x8
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("stall_pc", pc, 32'h8);
        chk("stall_valid", 32'(instr_valid), 32'h1);
        cyc(0, 0, 0, 0, 0);                 // pc 8 accepted

        // Redirect to 0x43 while hitting at 0xC
        cyc(0, 0, 1, 32'h43, 0);
        chk("redir_pc", pc, 32'h40);
        cyc(0, 0, 0, 0, 0);                 // miss at 0x40
        chk("redir_mem_addr", mem_addr, 32'h40);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);                 // hit 0x40

        // Redirect to 0x100 during the refill of 0x20
        cyc(0, 0, 1, 32'h20, 0);
        cyc(0, 0, 0, 0, 0);                 // miss at 0x20
        cyc(0, 1, 1, 32'h100, 0);           // redirect pending, stall ignored
        cyc(0, 0, 0, 0, 1);
        chk("pend_pc", pc, 32'h100);
        cyc(0, 0, 0, 0, 0);                 // miss at 0x100 (set 0)
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);                 // hit 0x100
        cyc(0, 0, 1, 32'h20, 0);
        chk("pend_line_hit", 32'(hit), 32'h1);
        cyc(0, 0, 0, 0, 0);
        chk("pend_line_no_req", 32'(mem_req), 32'h0);

        // Conflict: 0x000 was evicted by 0x100
        cyc(0, 0, 1, 32'h0, 0);
        chk("conflict_miss", 32'(hit), 32'h0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);

        // PC wrap at the top of the address space
        cyc(0, 0, 1, 32'hFFFF_FFFE, 0);
        chk("wrap_redir", pc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("wrap_plus4", pc_plus4, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0);

        // Reset during a refill; a later mem_ready in RUN is ignored
        cyc(0, 0, 1, 32'h200, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_pc", pc, 32'h0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        // Randomized traffic with frequent set conflicts and occasional wrap
        for (int i = 0; i < 800; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16))
                                      : ($urandom % 32'h400);
            cyc(($urandom % 200) == 0, ($urandom % 4) == 0,
                ($urandom % 10) == 0, rpc, ($urandom % 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
